// File: rtl/ps2_pkg.sv
// Shared types and scan-code constants for the PS/2 keyboard receiver.
package ps2_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_DATA,
        ST_PARITY,
        ST_STOP
    } ps2_state_t;

    localparam logic [7:0] PS2_BRK       = 8'hF0;
    localparam logic [7:0] PS2_EXT       = 8'hE0;
    localparam logic [7:0] PS2_PAUSE     = 8'hE1;
    localparam logic [2:0] PS2_PAUSE_LEN = 3'd7;

endpackage

// File: rtl/ps2_keyboard_rx_if.sv
// Key-event bus from the PS/2 receiver to the key-matrix block.
interface ps2_keyboard_rx_if;

    logic       strb;
    logic       make;
    logic [7:0] code;
    logic       ext;
    logic       err;

    modport master (output strb, make, code, ext, err);
    modport slave  (input  strb, make, code, ext, err);

endinterface

// File: rtl/ps2_filter.sv
// Two-flop synchroniser, FILTER-sample deglitcher and edge pulses for one PS/2 pin.
module ps2_filter #(
    parameter int unsigned FILTER = 8
) (
    input  logic clock,
    input  logic reset,
    input  logic i_pin,
    output logic o_level,
    output logic o_fall,
    output logic o_edge
);

    logic [1:0]        r_sync;
    logic [FILTER-1:0] r_shift;
    logic              r_level;
    logic              r_fall;
    logic              r_edge;

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_sync  <= '1;
            r_shift <= '1;
            r_level <= 1'b1;
            r_fall  <= 1'b0;
            r_edge  <= 1'b0;
        end else begin
            r_sync  <= {r_sync[0], i_pin};
            r_shift <= {r_shift[FILTER-2:0], r_sync[1]};
            r_fall  <= 1'b0;
            r_edge  <= 1'b0;
            // Level only flips once every sample in the window agrees.
            if (r_shift == '1 && !r_level) begin
                r_level <= 1'b1;
                r_edge  <= 1'b1;
            end else if (r_shift == '0 && r_level) begin
                r_level <= 1'b0;
                r_fall  <= 1'b1;
                r_edge  <= 1'b1;
            end
        end
    end

    assign o_level = r_level;
    assign o_fall  = r_fall;
    assign o_edge  = r_edge;

endmodule

// File: rtl/ps2_keyboard_rx.sv
// PS/2 keyboard receiver: deframes 11-bit frames and strips Set-2 E0/F0/E1 prefixes.
// Define PS2_PARITY_CHECK_EN to drop bytes with bad odd parity.
module ps2_keyboard_rx
    import ps2_pkg::*;
#(
    parameter int unsigned FILTER  = 8,
    parameter int unsigned TIMEOUT = 56000
) (
    input  logic               clock,
    input  logic               reset,
    input  logic               ps2ck,
    input  logic               ps2d,
    ps2_keyboard_rx_if.master  kbd
);

    localparam int unsigned    TW      = $clog2(TIMEOUT);
    localparam logic [TW-1:0]  TO_LAST = TW'(TIMEOUT - 1);

    logic w_ck_fall;
    logic w_ck_edge;
    logic w_d_level;

    ps2_filter #(.FILTER(FILTER)) u_ck_filter (
        .clock   (clock),
        .reset   (reset),
        .i_pin   (ps2ck),
        .o_level (),
        .o_fall  (w_ck_fall),
        .o_edge  (w_ck_edge)
    );

    ps2_filter #(.FILTER(FILTER)) u_d_filter (
        .clock   (clock),
        .reset   (reset),
        .i_pin   (ps2d),
        .o_level (w_d_level),
        .o_fall  (),
        .o_edge  ()
    );

    ps2_state_t    r_state;
    logic [2:0]    r_bitcnt;
    logic [7:0]    r_shift;
    logic [TW-1:0] r_tcnt;
    logic          r_brk;
    logic          r_extf;
    logic [2:0]    r_skip;
    logic          r_strb;
    logic          r_make;
    logic [7:0]    r_code;
    logic          r_ext;
    logic          r_err;
`ifdef PS2_PARITY_CHECK_EN
    logic          r_par;
`endif

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_bitcnt <= '0;
            r_shift  <= '0;
            r_tcnt   <= '0;
            r_brk    <= 1'b0;
            r_extf   <= 1'b0;
            r_skip   <= '0;
            r_strb   <= 1'b0;
            r_make   <= 1'b1;
            r_code   <= '0;
            r_ext    <= 1'b0;
            r_err    <= 1'b0;
`ifdef PS2_PARITY_CHECK_EN
            r_par    <= 1'b0;
`endif
        end else begin
            r_strb <= 1'b0;
            r_err  <= 1'b0;

            if (w_ck_edge || r_state == ST_IDLE)
                r_tcnt <= '0;
            else
                r_tcnt <= r_tcnt + 1'b1;

            // A clock edge always wins over the timeout, so strb and err cannot collide.
            if (!w_ck_edge && r_state != ST_IDLE && r_tcnt == TO_LAST) begin
                r_state  <= ST_IDLE;
                r_bitcnt <= '0;
                r_brk    <= 1'b0;
                r_extf   <= 1'b0;
                r_err    <= 1'b1;
            end else if (w_ck_fall) begin
                case (r_state)
                    ST_IDLE: begin
                        if (!w_d_level) begin
                            r_state  <= ST_DATA;
                            r_bitcnt <= '0;
                        end
                    end
                    ST_DATA: begin
                        r_shift  <= {w_d_level, r_shift[7:1]};
                        r_bitcnt <= r_bitcnt + 1'b1;
                        if (r_bitcnt == 3'd7)
                            r_state <= ST_PARITY;
                    end
                    ST_PARITY: begin
`ifdef PS2_PARITY_CHECK_EN
                        r_par   <= w_d_level;
`endif
                        r_state <= ST_STOP;
                    end
                    ST_STOP: begin
                        r_state <= ST_IDLE;
                        if (!w_d_level) begin
                            r_err <= 1'b1;
`ifdef PS2_PARITY_CHECK_EN
                        end else if (!(^{r_shift, r_par})) begin
                            r_err <= 1'b1;
`endif
                        end else if (r_skip != '0) begin
                            r_skip <= r_skip - 1'b1;
                        end else if (r_shift == PS2_PAUSE) begin
                            r_skip <= PS2_PAUSE_LEN;
                        end else if (r_shift == PS2_BRK) begin
                            r_brk <= 1'b1;
                        end else if (r_shift == PS2_EXT) begin
                            r_extf <= 1'b1;
                        end else begin
                            r_strb <= 1'b1;
                            r_code <= r_shift;
                            r_make <= r_brk;
                            r_ext  <= r_extf;
                            r_brk  <= 1'b0;
                            r_extf <= 1'b0;
                        end
                    end
                    default: r_state <= ST_IDLE;
                endcase
            end
        end
    end

    assign kbd.strb = r_strb;
    assign kbd.make = r_make;
    assign kbd.code = r_code;
    assign kbd.ext  = r_ext;
    assign kbd.err  = r_err;

endmodule

// File: tb/tb_ps2_keyboard_rx.sv
// Scoreboard bench for ps2_keyboard_rx: drives PS/2 frames and checks key/err events.
module tb_ps2_keyboard_rx;

    localparam int unsigned FILT = 8;
    localparam int unsigned TO   = 3000;
    localparam int unsigned HALF = 30;
    localparam int unsigned LAT  = FILT + 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic ps2ck = 1'b1;
    logic ps2d = 1'b1;

    ps2_keyboard_rx_if kbd_if ();

    ps2_keyboard_rx #(.FILTER(FILT), .TIMEOUT(TO)) dut (
        .clock (clk),
        .reset (rst_n),
        .ps2ck (ps2ck),
        .ps2d  (ps2d),
        .kbd   (kbd_if)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_err;
        bit         make;
        logic [7:0] code;
        bit         ext;
        bit         chk_lat;
    } exp_t;

    exp_t q[$];
    int   n_vec = 0;
    int   n_miss = 0;
    int   cyc = 0;
    int   cyc_stop = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_miss++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, obs, exp, $time);
        end
    endtask

    task automatic exp_key(input logic [7:0] c, input bit mk, input bit ex);
        exp_t e;
        e.is_err = 1'b0; e.make = mk; e.code = c; e.ext = ex; e.chk_lat = 1'b1;
        q.push_back(e);
    endtask

    task automatic exp_err(input bit lat);
        exp_t e;
        e.is_err = 1'b1; e.make = 1'b0; e.code = 8'h00; e.ext = 1'b0; e.chk_lat = lat;
        q.push_back(e);
    endtask

    // Scoreboard monitor, sampled on the falling clock edge.
    always @(negedge clk) begin
        if (rst_n && (kbd_if.strb || kbd_if.err)) begin
            if (kbd_if.strb) check_eq("strb_err_excl", {31'b0, kbd_if.err}, 32'd0);
            if (q.size() == 0) begin
                check_eq("unexpected_event", 32'(q.size()), 32'd1);
            end else begin
                exp_t e;
                e = q.pop_front();
                check_eq("event_kind", {31'b0, kbd_if.err}, {31'b0, e.is_err});
                if (!e.is_err) begin
                    check_eq("code", {24'b0, kbd_if.code}, {24'b0, e.code});
                    check_eq("make", {31'b0, kbd_if.make}, {31'b0, e.make});
                    check_eq("ext",  {31'b0, kbd_if.ext},  {31'b0, e.ext});
                end
                if (e.chk_lat) check_eq("latency", 32'(cyc - cyc_stop), 32'(LAT));
            end
        end
    end

    task automatic wait_clks(input int unsigned n);
        repeat (n) @(negedge clk);
    endtask

    task automatic send_bit(input logic b, input bit is_stop, input bit glitch);
        ps2d = b;
        if (glitch) begin
            wait_clks(10);
            ps2ck = 1'b0;
            wait_clks(FILT - 1);
            ps2ck = 1'b1;
            wait_clks(HALF - 10 - (FILT - 1));
        end else begin
            wait_clks(HALF);
        end
        ps2ck = 1'b0;
        if (is_stop) cyc_stop = cyc;
        wait_clks(HALF);
        ps2ck = 1'b1;
    endtask

    // nbits limits how many bits are sent (11 = full frame).
    task automatic send_frame(input logic [7:0] b, input bit flip_par, input logic stop,
                              input int nbits, input bit glitch);
        logic [10:0] fr;
        fr = {stop, (~^b) ^ flip_par, b, 1'b0};
        for (int i = 0; i < nbits; i++)
            send_bit(fr[i], i == 10, glitch && i == 3);
        ps2d = 1'b1;
        wait_clks(HALF);
    endtask

    task automatic send_byte(input logic [7:0] b);
        send_frame(b, 1'b0, 1'b1, 11, 1'b0);
    endtask

    initial begin
        logic [7:0] pause_seq [8];
        pause_seq = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

        wait_clks(5);
        check_eq("rst_strb", {31'b0, kbd_if.strb}, 32'd0);
        check_eq("rst_make", {31'b0, kbd_if.make}, 32'd1);
        check_eq("rst_code", {24'b0, kbd_if.code}, 32'h00);
        check_eq("rst_ext",  {31'b0, kbd_if.ext},  32'd0);
        check_eq("rst_err",  {31'b0, kbd_if.err},  32'd0);
        rst_n = 1'b1;
        wait_clks(20);

        exp_key(8'h1C, 1'b0, 1'b0);
        send_byte(8'h1C);

        exp_key(8'h1C, 1'b1, 1'b0);
        send_byte(8'hF0);
        send_byte(8'h1C);

        exp_key(8'h75, 1'b1, 1'b1);
        send_byte(8'hE0);
        send_byte(8'hF0);
        send_byte(8'h75);
        exp_key(8'h75, 1'b0, 1'b0);
        send_byte(8'h75);

        foreach (pause_seq[i]) send_byte(pause_seq[i]);
        exp_key(8'h1C, 1'b0, 1'b0);
        send_byte(8'h1C);
        wait_clks(100);
        check_eq("code_hold", {24'b0, kbd_if.code}, 32'h1C);

        exp_key(8'hAA, 1'b0, 1'b0);
        send_byte(8'hAA);
        exp_key(8'hFA, 1'b1, 1'b0);
        send_byte(8'hF0);
        send_byte(8'hFA);

        exp_err(1'b0);
        send_frame(8'h00, 1'b0, 1'b1, 5, 1'b0);
        wait_clks(TO + 100);
        check_eq("timeout_err_seen", 32'(q.size()), 32'd0);
        exp_key(8'h29, 1'b0, 1'b0);
        send_byte(8'h29);

        exp_err(1'b1);
        send_frame(8'h3A, 1'b0, 1'b0, 11, 1'b0);

`ifdef PS2_PARITY_CHECK_EN
        exp_err(1'b1);
`else
        exp_key(8'h1C, 1'b0, 1'b0);
`endif
        send_frame(8'h1C, 1'b1, 1'b1, 11, 1'b0);

        exp_key(8'h4B, 1'b0, 1'b0);
        send_frame(8'h4B, 1'b0, 1'b1, 11, 1'b1);

        send_frame(8'h55, 1'b0, 1'b1, 4, 1'b0);
        rst_n = 1'b0;
        wait_clks(3);
        check_eq("midrst_make", {31'b0, kbd_if.make}, 32'd1);
        check_eq("midrst_code", {24'b0, kbd_if.code}, 32'h00);
        rst_n = 1'b1;
        wait_clks(20);
        exp_key(8'h1C, 1'b0, 1'b0);
        send_byte(8'h1C);

        wait_clks(200);
        check_eq("drain", 32'(q.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

    initial begin
        #5ms;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1);
    end

endmodule

// File: doc/ps2_keyboard_rx.md
Name: ps2_keyboard_rx

Overview:
- PS/2 keyboard receiver and scan-code front end.
- Samples the keyboard's open-collector clock and data lines, deglitches them and deframes 11-bit device-to-host frames.
- Strips the Set-2 E0/F0 prefixes and emits one `strb`/`make`/`code` event per key action.
- Sits directly upstream of the Spectrum key-matrix block, which consumes `strb`, `make` and `code` unchanged.

Parameters:
- FILTER, 8: number of consecutive identical samples required before filtered `ps2ck`/`ps2d` change state.
- TIMEOUT, 56000: clocks without a filtered `ps2ck` edge before a partial frame is abandoned (about 2 ms at 28 MHz). Counter width is `$clog2(TIMEOUT)`.

Ports:
- clock  in  1  system clock; all logic is on its rising edge.
- reset  in  1  asynchronous, active-low reset.
- ps2ck  in  1  raw PS/2 clock pin, asynchronous.
- ps2d  in  1  raw PS/2 data pin, asynchronous.
- strb  out  1  one-cycle pulse: a key event is valid on `make`/`code`/`ext`.
- make  out  1  0 = key pressed, 1 = key released (active-low, matching the matrix).
- code  out  8  scan code with prefixes removed.
- ext  out  1  1 if the event was E0-prefixed.
- err  out  1  one-cycle pulse on framing, parity or timeout error.

Behaviour:
- Reset (`reset`=0, async) values: `strb`=0, `make`=1, `code`=8'h00, `ext`=0, `err`=0. State=IDLE, prefix flags clear, pause-skip count 0. Filtered lines=1.
- Input conditioning:
  - 2-FF synchroniser on each pin.
  - Then a FILTER-deep shift register; the filtered level changes only when all FILTER samples agree.
  - A falling edge of filtered `ps2ck` produces a one-cycle `fall` pulse. Filtered `ps2d` is sampled on that cycle.
- Frame FSM, advancing on `fall` only:
  - IDLE: bit=0 → DATA with bitcnt=0; bit=1 → stay IDLE (no err).
  - DATA: shift in LSB first; after bitcnt=7 → PARITY.
  - PARITY: store the bit → STOP.
  - STOP: bit=1 → byte accepted; bit=0 → `err` pulse. Both paths → IDLE.
- Byte decode, one clock after the `fall` of an accepted stop bit:
  - Pause-skip count>0: decrement it, no output.
  - 8'hE1: load the pause-skip count with 7, no output.
  - 8'hF0: set the brk flag, no output.
  - 8'hE0: set the ext flag, no output.
  - Any other byte: `strb`=1 for exactly one cycle, `code`=byte, `make`=brk, `ext`=ext flag. Both flags clear the same cycle.
- Latency: `strb` is asserted exactly 1 clock after the `fall` pulse of the stop bit.
- `code`/`make`/`ext` hold their values until the next event.
- Device replies (8'hAA, 8'hFA, 8'hEE, 8'hFE) pass through as ordinary codes with `make`=brk.
- Timeout:
  - The counter clears on every filtered `ps2ck` edge (either direction) and counts only while state≠IDLE.
  - On reaching TIMEOUT-1: state→IDLE, bitcnt→0, brk and ext flags clear, `err` pulses for one cycle.
  - The pause-skip count is preserved.
- `strb` and `err` never assert in the same cycle.
- Line held low forever: the FSM times out, then waits in IDLE. No further `err` is raised until a new frame starts.
- Reset mid-frame discards all partial state. There is no output event.

Optional Feature:
- Macro: PS2_PARITY_CHECK_EN.
- Defined: at the stop bit, odd parity over data+parity is checked. On mismatch the byte is dropped (no strb, prefix flags unchanged) and `err` pulses.
- Undefined: the parity bit is sampled and ignored. The parity-check logic is not synthesised.

Decomposition:
- Package `ps2_pkg`:
  - FSM state enum (IDLE, DATA, PARITY, STOP).
  - Constants PS2_BRK=8'hF0, PS2_EXT=8'hE0, PS2_PAUSE=8'hE1, PS2_PAUSE_LEN=7.
- Sub-module `ps2_filter`: synchroniser, FILTER-deep deglitch and falling-edge pulse. Instantiated once for the clock and once for the data, with the edge output unused on the data instance.

Test Plan:
- Frame 8'h1C with correct parity → single `strb`, `code`=8'h1C, `make`=0, `ext`=0, 1 clock after the stop `fall`.
- Bytes F0, 1C → no `strb` on F0; then `strb` with `code`=8'h1C, `make`=1, `ext`=0.
- Bytes E0, F0, 75 → one `strb` with `code`=8'h75, `make`=1, `ext`=1. A following plain 8'h75 gives `ext`=0, `make`=0.
- Bytes E1 14 77 E1 F0 14 F0 77, then 1C → no strb for the pause sequence; then `code`=8'h1C.
- 5 bits then silence → `err` pulse at TIMEOUT; a following valid frame 8'h29 decodes correctly.
- With PS2_PARITY_CHECK_EN: frame 8'h1C with flipped parity → `err`, no `strb`. Without the macro → `strb`, `code`=8'h1C. Separately, a `ps2ck` low glitch of FILTER-1 cycles → no state change.
